seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan scheduler for the 6-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 80 ++++++++
 tb/tb_seg_scan_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Producer-facing bundle of the scan controller: shadow-update handshake plus
// the sel/seg digit drive and frame marker.
interface seg_scan_ctrl_if;
  logic [23:0] data_in;
  logic [5:0]  dp_in;
  logic [5:0]  blank_in;
  logic        lz_en;
  logic        upd_req;
  logic        upd_ack;
  logic        frame_start;
  logic [5:0]  sel;
  logic [7:0]  seg;

  modport master (
    output data_in, dp_in, blank_in, lz_en, upd_req,
    input  upd_ack, frame_start, sel, seg
  );

  modport slave (
    input  data_in, dp_in, blank_in, lz_en, upd_req,
    output upd_ack, frame_start, sel, seg
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan scheduler: steps one digit per dwell period, decodes
// from a shadow copy that is only reloaded at scan-frame boundaries.
module seg_scan_ctrl #(
  parameter int CNT_MAX = 49_999
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  seg_scan_ctrl_if.slave  bus
);
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [23:0]     sh_data;
  logic [5:0]      sh_dp;
  logic [5:0]      sh_blank;
  logic            sh_lz;

  logic            cnt_wrap;
  logic            frame_end;
  logic            load;
  logic [5:0]      lz_blk;
  logic [5:0][7:0] dig_seg;

  assign cnt_wrap  = (cnt == CW'(CNT_MAX));
  assign frame_end = cnt_wrap && (idx == 3'd5);
  assign load      = frame_end && bus.upd_req;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Per-digit segment image; a digit is lz-dark when it and every digit above it is zero.
  for (genvar k = 0; k < 6; k++) begin : g_dig
    if (k == 0) begin : g_lsd
      assign lz_blk[k] = 1'b0;
    end else begin : g_hi
      assign lz_blk[k] = sh_lz && (sh_data[23:4*k] == '0);
    end
    assign dig_seg[k] = sh_blank[k] ? 8'hFF :
                        {~sh_dp[k], lz_blk[k] ? 7'h7F : hex7(sh_data[4*k +: 4])};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt             <= '0;
      idx             <= '0;
      sh_data         <= '0;
      sh_dp           <= '0;
      sh_blank        <= 6'h3F;
      sh_lz           <= 1'b0;
      bus.sel         <= 6'h00;
      bus.seg         <= 8'hFF;
      bus.upd_ack     <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

      // Shadow only moves at the frame boundary, so a frame is never mixed.
      if (load) begin
        sh_data  <= bus.data_in;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_in;
        sh_lz    <= bus.lz_en;
      end
      bus.upd_ack     <= load;
      bus.frame_start <= frame_end;

      bus.sel <= 6'b1 << idx;
      bus.seg <= dig_seg[idx];
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a short dwell (CNT_MAX=3, 24-cycle frames).
module tb_seg_scan_ctrl;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.CNT_MAX(3)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  bit   ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_frame(input logic [7:0] d0, d1, d2, d3, d4, d5);
    logic [5:0][7:0] s;
    s = {d5, d4, d3, d2, d1, d0};
    for (int k = 0; k < 6; k++) exp_q.push_back({6'b1 << k, s[k]});
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!bus.frame_start && n < 40);
    if (!bus.frame_start) begin
      tests++;
      fails++;
      $display("FAIL frame_start_timeout: got none after %0d cycles expected within 24", n);
    end
  endtask

  // Raise a request, wait for its ack, then queue the frame that must follow.
  task automatic do_update(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl,
                           input logic lz, input logic [7:0] e0, e1, e2, e3, e4, e5);
    int n = 0;
    bus.data_in  = d;
    bus.dp_in    = dp;
    bus.blank_in = bl;
    bus.lz_en    = lz;
    ack_q.push_back(1'b1);
    bus.upd_req  = 1'b1;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!bus.upd_ack && n < 60);
    tests++;
    if (!bus.upd_ack || n > 24) begin
      fails++;
      $display("FAIL ack_latency: got %0d cycles (ack=%0b) expected <= 24", n, bus.upd_ack);
    end
    push_frame(e0, e1, e2, e3, e4, e5);
    bus.upd_req = 1'b0;
    wait_fs();
  endtask

  // Monitor: pops an expectation each time a new digit is presented on sel.
  initial begin
    logic [5:0] psel;
    int last_chg, last_fs;
    exp_t e;
    psel = '0; last_chg = -1; last_fs = -1;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        psel = '0; last_chg = -1; last_fs = -1;
      end else begin
        if (bus.sel != psel) begin
          if (psel != 0 && bus.sel != 0) check("dwell", cyc - last_chg, 4);
          last_chg = cyc;
          if (bus.sel != 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sel", bus.sel, e.sel);
            check("seg", bus.seg, e.seg);
          end
          psel = bus.sel;
        end
        if (bus.frame_start) begin
          if (last_fs >= 0) check("frame_period", cyc - last_fs, 24);
          last_fs = cyc;
        end
        if (bus.upd_ack) begin
          tests++;
          if (ack_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_ack: got upd_ack=1 expected 0 (cycle %0d)", cyc);
          end else begin
            void'(ack_q.pop_front());
            if (bus.frame_start !== 1'b1) begin
              fails++;
              $display("FAIL ack_with_fs: got frame_start=%0b expected 1", bus.frame_start);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    bus.data_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.lz_en = 1'b0; bus.upd_req = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_sel", bus.sel, 6'h00);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_ack", bus.upd_ack, 1'b0);
    check("rst_fs",  bus.frame_start, 1'b0);

    // Dark display straight out of reset.
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    sys_rst = 1'b0;
    wait_fs();
    wait_fs();

    do_update(24'h123456, 6'h00, 6'h00, 1'b0, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    do_update(24'hABCDEF, 6'b100001, 6'b000010, 1'b0, 8'h0E, 8'hFF, 8'hA1, 8'hC6, 8'h83, 8'h08);

    // Mid-frame request: current frame must stay on the old values.
    wait_fs();
    push_frame(8'h0E, 8'hFF, 8'hA1, 8'hC6, 8'h83, 8'h08);
    repeat (9) @(negedge sys_clk);
    do_update(24'h654321, 6'h00, 6'h00, 1'b0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82);

    do_update(24'h000070, 6'b000100, 6'h00, 1'b1, 8'hC0, 8'hF8, 8'h7F, 8'hFF, 8'hFF, 8'hFF);
    do_update(24'h000000, 6'h00, 6'h00, 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    do_update(24'h000000, 6'h00, 6'h01, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    do_update(24'h100000, 6'h00, 6'h00, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9);

    // Reset at idx=3 with a pending request; load must land 24 cycles after release.
    wait_fs();
    bus.data_in = 24'h00E0C5; bus.dp_in = '0; bus.blank_in = '0; bus.lz_en = 1'b1;
    ack_q.push_back(1'b1);
    bus.upd_req = 1'b1;
    repeat (13) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check("midrst_sel", bus.sel, 6'h00);
    check("midrst_seg", bus.seg, 8'hFF);
    check("midrst_ack", bus.upd_ack, 1'b0);
    repeat (2) @(negedge sys_clk);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    sys_rst = 1'b0;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!bus.upd_ack && n < 60);
    check("post_rst_ack_latency", n, 24);
    push_frame(8'h92, 8'hC6, 8'hC0, 8'h86, 8'hFF, 8'hFF);
    bus.upd_req = 1'b0;
    wait_fs();

    check("exp_q_drained", exp_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
